write_master: RTL
=================

WRITE_MASTER -- requirements
Module: write_master

Interface
REQ-001 SHALL have: iClk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: iReset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: iStart  input  1  level-held go from control register; held until oDone observed.
REQ-004 SHALL have: iStartAddress  input  32  destination byte address.
REQ-005 SHALL have: iLength  input  32  transfer length in bytes.
REQ-006 SHALL have: oDone  output  1  one-cycle completion pulse.
REQ-007 SHALL have: oAddress  output  32  Avalon-MM master address, word-aligned.
REQ-008 SHALL have: oWrite  output  1  Avalon-MM write request.
REQ-009 SHALL have: oWritedata  output  32  write data.
REQ-010 SHALL have: oByteenable  output  4  byte enables.
REQ-011 SHALL have: iWaitrequest  input  1  slave stall.
REQ-012 SHALL have: iFifoData  input  32  show-ahead FIFO head word, valid when iFifoEmpty=0.
REQ-013 SHALL have: iFifoEmpty  input  1  FIFO empty flag.
REQ-014 SHALL have: oFifoRead  output  1  pop FIFO head.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRITE, DONE, HOLD.
REQ-016 IDLE: on iStart=1 -> LOAD; otherwise stay.
REQ-017 LOAD (1 cycle): latch address reg = {iStartAddress[31:2],2'b00}, word count reg = iLength[31:2]; iLength[1:0] ignored; -> WRITE if count nonzero, else -> DONE.
REQ-018 WRITE: oWrite = !iFifoEmpty; oWritedata = iFifoData; oAddress = address reg; oByteenable = 4'hF whenever oWrite=1, else 4'h0.
REQ-019 Accept = oWrite && !iWaitrequest; oFifoRead SHALL equal Accept (same cycle, combinational).
REQ-020 On Accept: count decrements by 1, address increments by 4 (mod 2^32, wraps at 0xFFFFFFFC -> 0x00000000).
REQ-021 While iWaitrequest=1 with oWrite=1: oAddress, oWritedata held stable; no pop; no count change.
REQ-022 FIFO empty in WRITE: oWrite=0, stay in WRITE, no timeout.
REQ-023 Accept with count=1 -> DONE; no further oWrite that cycle onward.
REQ-024 DONE: oDone=1 for exactly one cycle; -> HOLD.
REQ-025 HOLD: stay until iStart=0, then -> IDLE; prevents retrigger from still-high go.
REQ-026 iStart deassert during LOAD/WRITE SHALL be ignored; transfer runs to completion.
REQ-027 Throughput: one word per cycle when FIFO non-empty and iWaitrequest=0.
REQ-028 Latency: first oWrite no earlier than 2nd rising edge after iStart sampled high (IDLE->LOAD->WRITE).
REQ-029 Outside WRITE: oWrite=0, oFifoRead=0, oByteenable=0.

Reset
REQ-030 iReset_n=0 SHALL asynchronously force IDLE, address reg=0, count=0; outputs oDone=0, oWrite=0, oFifoRead=0, oAddress=0, oByteenable=0; oWritedata don't-care.
REQ-031 Reset mid-transfer SHALL abandon transfer; no oDone issued; unpopped FIFO data untouched.

Configuration
REQ-032 Macro WRITE_MASTER_FIXED_ADDR_EN defined: address reg SHALL NOT increment on Accept (all words to iStartAddress word, peripheral-FIFO target); undefined: increment by 4 per REQ-020.

Verification
REQ-033 iStartAddress=0x1000, iLength=16, FIFO holds A,B,C,D, no wait -> writes 0x1000/A,0x1004/B,0x1008/C,0x100C/D consecutive cycles, one oDone, 4 pops.
REQ-034 iLength=8, iWaitrequest=1 for 3 cycles on first write -> address/data held 3 cycles, 2 pops total, oDone after 2nd accept.
REQ-035 iLength=3 (or 0) -> no oWrite, oDone pulse 2 cycles after iStart, then HOLD until iStart=0.
REQ-036 iStartAddress=0xFFFFFFFC, iLength=8 -> writes 0xFFFFFFFC then 0x00000000; with WRITE_MASTER_FIXED_ADDR_EN both to 0xFFFFFFFC.
REQ-037 FIFO empty 5 cycles mid-transfer, then refilled -> oWrite low during gap, resumes, correct count.
REQ-038 iReset_n low after 2 of 4 words -> immediate IDLE, outputs zero, no oDone; new iStart runs a fresh transfer.

Source files
------------

// File: rtl/write_master.sv
// rtl/write_master.sv - Avalon-MM write master draining a show-ahead FIFO to memory.
// Define WRITE_MASTER_FIXED_ADDR_EN to keep every write at the start word (peripheral FIFO target).
module write_master (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic [31:0] iStartAddress,
    input  logic [31:0] iLength,
    output logic        oDone,
    output logic [31:0] oAddress,
    output logic        oWrite,
    output logic [31:0] oWritedata,
    output logic [3:0]  oByteenable,
    input  logic        iWaitrequest,
    input  logic [31:0] iFifoData,
    input  logic        iFifoEmpty,
    output logic        oFifoRead
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [29:0] count_q;
    logic        accept;

    // Sub-word start offset and trailing partial word are intentionally dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^{iStartAddress[1:0], iLength[1:0]};

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            addr_q  <= 32'd0;
            count_q <= 30'd0;
        end else if (state == S_LOAD) begin
            addr_q  <= {iStartAddress[31:2], 2'b00};
            count_q <= iLength[31:2];
        end else if (accept) begin
            count_q <= count_q - 30'd1;
`ifdef WRITE_MASTER_FIXED_ADDR_EN
            addr_q  <= addr_q;
`else
            addr_q  <= addr_q + 32'd4;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        oWrite    = 1'b0;
        oDone     = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (iStart) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = (iLength[31:2] != 30'd0) ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                oWrite = !iFifoEmpty;
                accept = !iFifoEmpty && !iWaitrequest;
                if (accept && count_q == 30'd1) state_nxt = S_DONE;
            end
            S_DONE: begin
                oDone     = 1'b1;
                state_nxt = S_HOLD;
            end
            // Wait for the go level to drop so a still-high start cannot retrigger.
            S_HOLD: begin
                if (!iStart) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign oFifoRead   = accept;
    assign oByteenable = {4{oWrite}};
    assign oAddress    = addr_q;
    assign oWritedata  = iFifoData;

endmodule
